stable_counter_timer: RTL and testbench

- Responder for the RDCNTVL.W / RDCNTVH.W / RDCNTID instructions produced by the ID-stage rdcnt decode.
- Owns the 64-bit stable counter, the TID CSR and the LoongArch constant-frequency timer (TCFG/TVAL/TICLR). Raises the timer interrupt bit consumed by ESTAT.IS[11].
- Sits beside the CSR file. Serves EX-stage counter reads over a valid/ready handshake and CSR reads/writes over the CSR port.

---
 rtl/stable_counter_timer_pkg.sv | 27 ++
 rtl/stable_counter_timer_timer_core.sv | 67 ++++++
 rtl/stable_counter_timer.sv | 109 ++++++++++
 tb/tb_stable_counter_timer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stable_counter_timer_pkg.sv
// Shared encodings for the stable counter / timer block: rdcnt opcodes,
// CSR numbers, TCFG field positions and the masked CSR write helper.
package stable_counter_timer_pkg;

  typedef enum logic [1:0] {
    RDCNT_OP_VL  = 2'd0,
    RDCNT_OP_VH  = 2'd1,
    RDCNT_OP_ID  = 2'd2,
    RDCNT_OP_RSV = 2'd3
  } rdcnt_op_e;

  localparam logic [13:0] CSR_TID   = 14'h40;
  localparam logic [13:0] CSR_TCFG  = 14'h41;
  localparam logic [13:0] CSR_TVAL  = 14'h42;
  localparam logic [13:0] CSR_TICLR = 14'h44;

  localparam int TCFG_EN          = 0;
  localparam int TCFG_PERIODIC    = 1;
  localparam int TCFG_INITVAL_LSB = 2;

  function automatic logic [31:0] masked_write(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [31:0] wmask);
    return (old_val & ~wmask) | (wdata & wmask);
  endfunction

endpackage

// File: rtl/stable_counter_timer_timer_core.sv
// Constant-frequency timer: TCFG, TVAL down-counter and the sticky timer
// interrupt, with masked TCFG writes and TICLR clears from the parent.
module stable_counter_timer_timer_core
  import stable_counter_timer_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tcfg_we,
  input  logic               ticlr_clr,
  input  logic [31:0]        csr_wmask,
  input  logic [31:0]        csr_wdata,
  output logic [TIMER_W-1:0] tcfg,
  output logic [TIMER_W-1:0] tval,
  output logic               timer_int
);

  logic [TIMER_W-1:0] tcfg_reg;
  logic [TIMER_W-1:0] tcfg_next;
  logic [TIMER_W-1:0] tval_reg;
  logic [TIMER_W-1:0] reload_val;
  logic [TIMER_W-1:0] load_val;
  logic               int_reg;
  logic               expire;

  genvar gi;
  generate
    for (gi = 0; gi < TIMER_W; gi++) begin : g_tcfg_bit
      assign tcfg_next[gi] = csr_wmask[gi] ? csr_wdata[gi] : tcfg_reg[gi];
    end
  endgenerate

  assign reload_val = {tcfg_reg[TIMER_W-1:TCFG_INITVAL_LSB], 2'b00};
  assign load_val   = {tcfg_next[TIMER_W-1:TCFG_INITVAL_LSB], 2'b00};
  assign expire     = tcfg_reg[TCFG_EN] && (tval_reg == TIMER_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg_reg <= '0;
      tval_reg <= '0;
      int_reg  <= 1'b0;
    end else begin
      // A TCFG write restarts the timer and overrides this cycle's countdown.
      if (tcfg_we) begin
        tcfg_reg <= tcfg_next;
        tval_reg <= load_val;
      end else if (tcfg_reg[TCFG_EN]) begin
        if (tval_reg != '0)
          tval_reg <= tval_reg - TIMER_W'(1);
        else if (tcfg_reg[TCFG_PERIODIC])
          tval_reg <= reload_val;
      end

      // Expiry set beats a simultaneous TICLR clear.
      if (expire && !tcfg_we)
        int_reg <= 1'b1;
      else if (ticlr_clr)
        int_reg <= 1'b0;
    end
  end

  assign tcfg      = tcfg_reg;
  assign tval      = tval_reg;
  assign timer_int = int_reg;

endmodule

// File: rtl/stable_counter_timer.sv
// RDCNT responder: 64-bit stable counter, TID CSR, counter-read handshake
// toward EX, and the CSR port for TID/TCFG/TVAL/TICLR.
module stable_counter_timer
  import stable_counter_timer_pkg::*;
#(
  parameter int          CNT_W     = 64,
  parameter int          TIMER_W   = 32,
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_valid,
  input  logic [1:0]  rd_op,
  output logic        rd_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  input  logic        csr_we,
  input  logic [13:0] csr_num,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wdata,
  output logic        csr_hit,
  output logic [31:0] csr_rdata,
  output logic        timer_int
);

  logic [CNT_W-1:0]   cnt_reg;
  logic [CNT_W-1:0]   cnt_next;
  logic [31:0]        tid_reg;
  logic [31:0]        tid_next;
  logic               resp_valid_reg;
  logic [31:0]        resp_data_reg;
  logic [31:0]        rd_value;
  logic               accept;
  logic               tid_we;
  logic               tcfg_we;
  logic               ticlr_clr;
  logic [TIMER_W-1:0] tcfg;
  logic [TIMER_W-1:0] tval;

  assign cnt_next  = cnt_reg + CNT_W'(1);
  assign rd_ready  = !resp_valid_reg || resp_ready;
  assign accept    = rd_valid && rd_ready;
  assign tid_we    = csr_we && (csr_num == CSR_TID);
  assign tcfg_we   = csr_we && (csr_num == CSR_TCFG);
  assign ticlr_clr = csr_we && (csr_num == CSR_TICLR) && csr_wmask[0] && csr_wdata[0];
  assign tid_next  = masked_write(tid_reg, csr_wdata, csr_wmask);

  // Sampled from the current registers, so a same-cycle TID write returns the old TID.
  always_comb begin
    rd_value = '0;
    case (rdcnt_op_e'(rd_op))
      RDCNT_OP_VL:  rd_value = cnt_reg[31:0];
      RDCNT_OP_VH:  rd_value = 32'(cnt_reg[CNT_W-1:32]);
      RDCNT_OP_ID:  rd_value = tid_reg;
      RDCNT_OP_RSV: rd_value = '0;
      default:      rd_value = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg        <= '0;
      tid_reg        <= TID_RESET;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
    end else begin
      cnt_reg <= cnt_next;
      if (tid_we)
        tid_reg <= tid_next;
      if (accept) begin
        resp_valid_reg <= 1'b1;
        resp_data_reg  <= rd_value;
      end else if (resp_ready) begin
        resp_valid_reg <= 1'b0;
      end
    end
  end

  assign resp_valid = resp_valid_reg;
  assign resp_data  = resp_data_reg;

  stable_counter_timer_timer_core #(
    .TIMER_W(TIMER_W)
  ) u_timer_core (
    .clk       (clk),
    .reset     (reset),
    .tcfg_we   (tcfg_we),
    .ticlr_clr (ticlr_clr),
    .csr_wmask (csr_wmask),
    .csr_wdata (csr_wdata),
    .tcfg      (tcfg),
    .tval      (tval),
    .timer_int (timer_int)
  );

  always_comb begin
    csr_hit   = 1'b1;
    csr_rdata = '0;
    case (csr_num)
      CSR_TID:   csr_rdata = tid_reg;
      CSR_TCFG:  csr_rdata = 32'(tcfg);
      CSR_TVAL:  csr_rdata = 32'(tval);
      CSR_TICLR: csr_rdata = '0;
      default:   csr_hit   = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_stable_counter_timer.sv
// Directed bench for stable_counter_timer: a vector table for the read
// handshake and CSR port, plus hand-written timer and counter-wrap sequences.
module tb_stable_counter_timer;
  import stable_counter_timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_valid = 1'b0;
  logic [1:0]  rd_op = 2'd0;
  logic        rd_ready;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        csr_we = 1'b0;
  logic [13:0] csr_num = 14'h0;
  logic [31:0] csr_wmask = 32'h0;
  logic [31:0] csr_wdata = 32'h0;
  logic        csr_hit;
  logic [31:0] csr_rdata;
  logic        timer_int;

  int checks = 0;
  int failures = 0;

  stable_counter_timer #(
    .CNT_W(64), .TIMER_W(32), .TID_RESET(32'h0)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_valid(rd_valid), .rd_op(rd_op), .rd_ready(rd_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wdata(csr_wdata),
    .csr_hit(csr_hit), .csr_rdata(csr_rdata), .timer_int(timer_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [1:0]  op;
    logic        rr;
    logic        we;
    logic [13:0] num;
    logic [31:0] mask;
    logic [31:0] wdata;
    logic        x_rdy;
    logic        x_hit;
    logic [31:0] x_rdata;
    logic        x_vld;
    logic [31:0] x_data;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic rv, input logic [1:0] op, input logic rr,
                              input logic we, input logic [13:0] num,
                              input logic [31:0] mask, input logic [31:0] wdata,
                              input logic x_rdy, input logic x_hit, input logic [31:0] x_rdata,
                              input logic x_vld, input logic [31:0] x_data);
    vec_t v;
    v.rv = rv; v.op = op; v.rr = rr; v.we = we; v.num = num; v.mask = mask; v.wdata = wdata;
    v.x_rdy = x_rdy; v.x_hit = x_hit; v.x_rdata = x_rdata; v.x_vld = x_vld; v.x_data = x_data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic csr_rd_chk(input string name, input logic [13:0] num, input logic [31:0] exp);
    csr_num = num;
    #1;
    chk(name, csr_rdata, exp);
  endtask

  task automatic csr_wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] data);
    csr_we = 1'b1; csr_num = num; csr_wmask = mask; csr_wdata = data;
    step();
    csr_we = 1'b0; csr_wmask = 32'h0; csr_wdata = 32'h0;
    $display("csr write num=%0h mask=%08h data=%08h", num, mask, data);
  endtask

  task automatic timer_chk(input string name, input logic [31:0] exp_tval, input logic exp_int);
    csr_rd_chk({name, " tval"}, CSR_TVAL, exp_tval);
    chk({name, " timer_int"}, timer_int, exp_int);
  endtask

  initial begin
    // Cycle k after reset sees cnt==k; a request in cycle k returns k.
    vecs[0]  = mk(1, RDCNT_OP_VL,  1, 0, CSR_TID,   32'h0,        32'h0,        1, 1, 32'h0,    1, 32'd10);
    vecs[1]  = mk(0, RDCNT_OP_VL,  1, 0, CSR_TCFG,  32'h0,        32'h0,        1, 1, 32'h0,    0, 32'd10);
    vecs[2]  = mk(1, RDCNT_OP_ID,  1, 1, CSR_TID,   32'hFFFF_FFFF, 32'h5,       1, 1, 32'h0,    1, 32'h0);
    vecs[3]  = mk(1, RDCNT_OP_ID,  1, 0, CSR_TID,   32'h0,        32'h0,        1, 1, 32'h5,    1, 32'h5);
    vecs[4]  = mk(1, RDCNT_OP_RSV, 1, 1, CSR_TID,   32'h0000_FF00, 32'hABCD_1234, 1, 1, 32'h5,  1, 32'h0);
    vecs[5]  = mk(1, RDCNT_OP_ID,  1, 0, CSR_TID,   32'h0,        32'h0,        1, 1, 32'h1205, 1, 32'h1205);
    vecs[6]  = mk(0, RDCNT_OP_VL,  1, 0, CSR_TVAL,  32'h0,        32'h0,        1, 1, 32'h0,    0, 32'h1205);
    vecs[7]  = mk(1, RDCNT_OP_VL,  0, 0, CSR_TICLR, 32'h0,        32'h0,        1, 1, 32'h0,    1, 32'd17);
    vecs[8]  = mk(1, RDCNT_OP_VH,  0, 0, 14'h43,    32'h0,        32'h0,        0, 0, 32'h0,    1, 32'd17);
    vecs[9]  = mk(1, RDCNT_OP_VH,  0, 0, 14'h43,    32'h0,        32'h0,        0, 0, 32'h0,    1, 32'd17);
    vecs[10] = mk(1, RDCNT_OP_VH,  0, 0, 14'h43,    32'h0,        32'h0,        0, 0, 32'h0,    1, 32'd17);
    vecs[11] = mk(1, RDCNT_OP_VH,  1, 0, CSR_TID,   32'h0,        32'h0,        1, 1, 32'h1205, 1, 32'h0);
    vecs[12] = mk(1, RDCNT_OP_VL,  1, 0, CSR_TID,   32'h0,        32'h0,        1, 1, 32'h1205, 1, 32'd22);
    vecs[13] = mk(0, RDCNT_OP_VL,  1, 0, 14'h0,     32'h0,        32'h0,        1, 0, 32'h0,    0, 32'd22);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset resp_valid", resp_valid, 1'b0);
    chk("reset resp_data", resp_data, 32'h0);
    chk("reset timer_int", timer_int, 1'b0);
    chk("reset rd_ready", rd_ready, 1'b1);
    csr_rd_chk("reset tid", CSR_TID, 32'h0);
    csr_rd_chk("reset tcfg", CSR_TCFG, 32'h0);
    csr_rd_chk("reset tval", CSR_TVAL, 32'h0);
    chk("reset tval hit", csr_hit, 1'b1);
    reset = 1'b0;
    repeat (10) step();

    for (int i = 0; i < NV; i++) begin
      rd_valid = vecs[i].rv; rd_op = vecs[i].op; resp_ready = vecs[i].rr;
      csr_we = vecs[i].we; csr_num = vecs[i].num;
      csr_wmask = vecs[i].mask; csr_wdata = vecs[i].wdata;
      #1;
      chk($sformatf("v%0d rd_ready", i), rd_ready, vecs[i].x_rdy);
      chk($sformatf("v%0d csr_hit", i), csr_hit, vecs[i].x_hit);
      chk($sformatf("v%0d csr_rdata", i), csr_rdata, vecs[i].x_rdata);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d resp_valid", i), resp_valid, vecs[i].x_vld);
      chk($sformatf("v%0d resp_data", i), resp_data, vecs[i].x_data);
      $display("vec %0d rv=%0b op=%0d rr=%0b -> resp_valid=%0b resp_data=%08h",
               i, vecs[i].rv, vecs[i].op, vecs[i].rr, resp_valid, resp_data);
      @(negedge clk);
    end
    rd_valid = 1'b0; resp_ready = 1'b1; csr_we = 1'b0; csr_wmask = 32'h0; csr_wdata = 32'h0;

    // Periodic timer, InitVal=2: 8..1,0 with interrupt, then reload to 8.
    csr_wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_000B);
    csr_rd_chk("tcfg periodic", CSR_TCFG, 32'h0000_000B);
    for (int k = 0; k <= 9; k++) begin
      timer_chk($sformatf("periodic k%0d", k), (k <= 8) ? 32'(8 - k) : 32'd8, k >= 8);
      if (k < 9) step();
    end
    csr_wr(CSR_TVAL, 32'hFFFF_FFFF, 32'h55);
    timer_chk("tval write ignored", 32'd7, 1'b1);
    csr_wr(CSR_TICLR, 32'h1, 32'h1);
    timer_chk("ticlr clear", 32'd6, 1'b0);
    repeat (5) step();
    timer_chk("before expiry", 32'd1, 1'b0);
    csr_wr(CSR_TICLR, 32'h1, 32'h1);
    timer_chk("clear on expiry", 32'd0, 1'b1);
    step();
    timer_chk("periodic reload", 32'd8, 1'b1);

    // One-shot timer, InitVal=1.
    csr_wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0005);
    timer_chk("oneshot load", 32'd4, 1'b1);
    csr_wr(CSR_TICLR, 32'h0, 32'h1);
    timer_chk("ticlr masked off", 32'd3, 1'b1);
    csr_wr(CSR_TICLR, 32'h1, 32'h1);
    timer_chk("oneshot clear", 32'd2, 1'b0);
    step();
    timer_chk("oneshot tval1", 32'd1, 1'b0);
    step();
    timer_chk("oneshot expire", 32'd0, 1'b1);
    repeat (2) step();
    timer_chk("oneshot stopped", 32'd0, 1'b1);

    // TCFG write on the expiry cycle: reload, no interrupt.
    csr_wr(CSR_TICLR, 32'h1, 32'h1);
    timer_chk("idle clear", 32'd0, 1'b0);
    csr_wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0005);
    repeat (3) step();
    timer_chk("pre-collision", 32'd1, 1'b0);
    csr_wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0009);
    timer_chk("tcfg wins expiry", 32'd8, 1'b0);
    step();
    timer_chk("after collision", 32'd7, 1'b0);

    // Periodic with InitVal=0 stays stopped.
    csr_wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0003);
    repeat (3) step();
    timer_chk("periodic zero", 32'd0, 1'b0);

    // En=0 holds TVAL; masked TCFG write sets only En and reloads.
    csr_wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0008);
    repeat (2) step();
    timer_chk("disabled hold", 32'd8, 1'b0);
    csr_wr(CSR_TCFG, 32'h0000_0001, 32'hFFFF_FFFF);
    csr_rd_chk("tcfg masked", CSR_TCFG, 32'h0000_0009);
    step();
    timer_chk("masked enable", 32'd7, 1'b0);

    // Counter carry across bit 32 and full wrap.
    force dut.cnt_reg = 64'h0000_0000_FFFF_FFFF;
    rd_valid = 1'b1; rd_op = RDCNT_OP_VL; resp_ready = 1'b1;
    #1;
    chk("cnt carry", dut.cnt_next, 64'h0000_0001_0000_0000);
    step();
    chk("vl hi boundary valid", resp_valid, 1'b1);
    chk("vl hi boundary", resp_data, 32'hFFFF_FFFF);
    $display("vl read -> %08h", resp_data);
    force dut.cnt_reg = 64'h0000_0001_0000_0000;
    rd_op = RDCNT_OP_VH;
    step();
    chk("vh after carry", resp_data, 32'h1);
    $display("vh read -> %08h", resp_data);
    force dut.cnt_reg = 64'hFFFF_FFFF_FFFF_FFFF;
    rd_op = RDCNT_OP_VL; resp_ready = 1'b0;
    #1;
    chk("cnt wrap", dut.cnt_next, 64'h0);
    chk("stall rd_ready", rd_ready, 1'b0);

    // Reset with a pending response clears it and restarts the counter.
    reset = 1'b1;
    release dut.cnt_reg;
    step();
    chk("midreset resp_valid", resp_valid, 1'b0);
    chk("midreset resp_data", resp_data, 32'h0);
    csr_rd_chk("midreset tid", CSR_TID, 32'h0);
    csr_rd_chk("midreset tcfg", CSR_TCFG, 32'h0);
    csr_rd_chk("midreset tval", CSR_TVAL, 32'h0);
    step();
    reset = 1'b0; rd_valid = 1'b0; resp_ready = 1'b1;
    repeat (3) step();
    rd_valid = 1'b1; rd_op = RDCNT_OP_VL;
    step();
    rd_valid = 1'b0;
    chk("post-reset vl valid", resp_valid, 1'b1);
    chk("post-reset vl", resp_data, 32'd3);
    $display("post-reset vl read -> %08h", resp_data);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
